// File: rtl/sap_control_sequencer.sv
// rtl/sap_control_sequencer.sv - fetch/execute T-state sequencer for the 8-bit accumulator CPU
//
// Steps T1..T5 (or HALT), holds the instruction register, and decodes state
// and IR into the bus drive/load strobes for PC, MAR, ROM, IR, A, B, ALU, OUT
// and the return-address register.
//
// Ports:
//   clk, rst (sync, active-high), run (step enable)
//   bus_in      : shared bus, captured into IR at the end of T2
//   ir_operand  : IR[3:0], ir_opcode : IR[7:4]
//   t_state     : 0..4 = T1..T5, 7 = HALT
//   PC_OUT/PC_INC/PC_LOAD, MAR_LOAD, ROM_LOW_OE (active-low), IR_LOAD/IR_OUT,
//   A_LOAD/A_OUT, B_LOAD, ALU_OUT/ALU_SUB, OUT_LOAD, RA_LOAD/RA_OUT : strobes
//   HALTED      : high while in HALT
module sap_control_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [7:0] bus_in,
  output logic [3:0] ir_operand,
  output logic [3:0] ir_opcode,
  output logic [2:0] t_state,
  output logic       PC_OUT,
  output logic       PC_INC,
  output logic       PC_LOAD,
  output logic       MAR_LOAD,
  output logic       ROM_LOW_OE,
  output logic       IR_LOAD,
  output logic       IR_OUT,
  output logic       A_LOAD,
  output logic       A_OUT,
  output logic       B_LOAD,
  output logic       ALU_OUT,
  output logic       ALU_SUB,
  output logic       OUT_LOAD,
  output logic       RA_LOAD,
  output logic       RA_OUT,
  output logic       HALTED
);

  typedef enum logic [2:0] {
    T1   = 3'd0,
    T2   = 3'd1,
    T3   = 3'd2,
    T4   = 3'd3,
    T5   = 3'd4,
    HALT = 3'd7
  } state_t;

  localparam logic [3:0] OP_LDA  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_BUN  = 4'h5;
  localparam logic [3:0] OP_CALL = 4'h6;
  localparam logic [3:0] OP_RET  = 4'h7;
  localparam logic [3:0] OP_OUT  = 4'h8;
  localparam logic [3:0] OP_HLT  = 4'hF;

  state_t     state;
  logic [7:0] ir;
  logic [3:0] op;

  assign op         = ir[7:4];
  assign ir_operand = ir[3:0];
  assign ir_opcode  = ir[7:4];
  assign t_state    = state;
  // Reset overrides every output, HALTED included, so the flag drops as soon as rst rises.
  assign HALTED     = (state == HALT) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= T1;
      ir    <= 8'h00;
    end else if (run) begin
      case (state)
        T1: state <= T2;
        T2: begin
          ir    <= bus_in;
          state <= T3;
        end
        T3: begin
          case (op)
            OP_LDA, OP_ADD, OP_SUB, OP_CALL: state <= T4;
            OP_HLT:                          state <= HALT;
            default:                         state <= T1;
          endcase
        end
        T4:      state <= (op == OP_ADD || op == OP_SUB) ? T5 : T1;
        T5:      state <= T1;
        HALT:    state <= HALT;
        default: state <= T1;
      endcase
    end
  end

  // Strobes are a pure decode; rst or a stall masks them all so no datapath
  // register loads and the ROM stays off the bus.
  always_comb begin
    PC_OUT     = 1'b0;
    PC_INC     = 1'b0;
    PC_LOAD    = 1'b0;
    MAR_LOAD   = 1'b0;
    ROM_LOW_OE = 1'b1;
    IR_LOAD    = 1'b0;
    IR_OUT     = 1'b0;
    A_LOAD     = 1'b0;
    A_OUT      = 1'b0;
    B_LOAD     = 1'b0;
    ALU_OUT    = 1'b0;
    ALU_SUB    = 1'b0;
    OUT_LOAD   = 1'b0;
    RA_LOAD    = 1'b0;
    RA_OUT     = 1'b0;
    if (!rst && run) begin
      case (state)
        T1: begin
          PC_OUT   = 1'b1;
          MAR_LOAD = 1'b1;
        end
        T2: begin
          ROM_LOW_OE = 1'b0;
          IR_LOAD    = 1'b1;
          PC_INC     = 1'b1;
        end
        T3: begin
          case (op)
            OP_LDA, OP_ADD, OP_SUB: begin
              IR_OUT   = 1'b1;
              MAR_LOAD = 1'b1;
            end
            OP_BUN: begin
              IR_OUT  = 1'b1;
              PC_LOAD = 1'b1;
            end
            OP_CALL: begin
              PC_OUT  = 1'b1;
              RA_LOAD = 1'b1;
            end
            OP_RET: begin
              RA_OUT  = 1'b1;
              PC_LOAD = 1'b1;
            end
            OP_OUT: begin
              A_OUT    = 1'b1;
              OUT_LOAD = 1'b1;
            end
            default: ;
          endcase
        end
        T4: begin
          case (op)
            OP_LDA: begin
              ROM_LOW_OE = 1'b0;
              A_LOAD     = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ROM_LOW_OE = 1'b0;
              B_LOAD     = 1'b1;
            end
            OP_CALL: begin
              IR_OUT  = 1'b1;
              PC_LOAD = 1'b1;
            end
            default: ;
          endcase
        end
        T5: begin
          ALU_OUT = 1'b1;
          A_LOAD  = 1'b1;
          ALU_SUB = (op == OP_SUB);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sap_control_sequencer.sv
// tb/tb_sap_control_sequencer.sv - scoreboard bench for sap_control_sequencer
module tb_sap_control_sequencer;

  logic       clk;
  logic       rst;
  logic       run;
  logic [7:0] bus_in;
  logic [3:0] ir_operand;
  logic [3:0] ir_opcode;
  logic [2:0] t_state;
  logic PC_OUT, PC_INC, PC_LOAD, MAR_LOAD, ROM_LOW_OE, IR_LOAD, IR_OUT;
  logic A_LOAD, A_OUT, B_LOAD, ALU_OUT, ALU_SUB, OUT_LOAD, RA_LOAD, RA_OUT, HALTED;

  sap_control_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .bus_in(bus_in),
    .ir_operand(ir_operand), .ir_opcode(ir_opcode), .t_state(t_state),
    .PC_OUT(PC_OUT), .PC_INC(PC_INC), .PC_LOAD(PC_LOAD), .MAR_LOAD(MAR_LOAD),
    .ROM_LOW_OE(ROM_LOW_OE), .IR_LOAD(IR_LOAD), .IR_OUT(IR_OUT),
    .A_LOAD(A_LOAD), .A_OUT(A_OUT), .B_LOAD(B_LOAD), .ALU_OUT(ALU_OUT),
    .ALU_SUB(ALU_SUB), .OUT_LOAD(OUT_LOAD), .RA_LOAD(RA_LOAD), .RA_OUT(RA_OUT),
    .HALTED(HALTED)
  );

  // Strobe bit positions; ROM is recorded as "driving" (ROM_LOW_OE==0).
  localparam logic [14:0] NONE = 15'h0;
  localparam logic [14:0] S_PC_OUT = 15'h0001, S_PC_INC = 15'h0002, S_PC_LOAD = 15'h0004;
  localparam logic [14:0] S_MAR = 15'h0008, S_ROM = 15'h0010, S_IR_LOAD = 15'h0020;
  localparam logic [14:0] S_IR_OUT = 15'h0040, S_A_LOAD = 15'h0080, S_A_OUT = 15'h0100;
  localparam logic [14:0] S_B_LOAD = 15'h0200, S_ALU_OUT = 15'h0400, S_ALU_SUB = 15'h0800;
  localparam logic [14:0] S_OUT_LOAD = 15'h1000, S_RA_LOAD = 15'h2000, S_RA_OUT = 15'h4000;
  localparam logic [14:0] FETCH1 = S_PC_OUT | S_MAR;
  localparam logic [14:0] FETCH2 = S_ROM | S_IR_LOAD | S_PC_INC;

  typedef struct {
    string       name;
    logic        skip;
    logic [2:0]  t;
    logic        h;
    logic [14:0] s;
    logic [7:0]  ir;
  } exp_t;

  exp_t exp_q[$];
  int   compared;
  int   mismatched;
  int   cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One stimulus cycle: apply inputs just after the edge, push what that cycle must show.
  task automatic step(input string name, input logic r, input logic rn, input logic [7:0] b,
                      input logic [2:0] t, input logic h, input logic [14:0] s,
                      input logic [7:0] ir, input logic skip = 1'b0);
    exp_t e;
    @(posedge clk);
    #1;
    rst    = r;
    run    = rn;
    bus_in = b;
    e.name = name; e.skip = skip; e.t = t; e.h = h; e.s = s; e.ir = ir;
    exp_q.push_back(e);
  endtask

  // Monitor: sample mid-cycle, pop and compare one expectation per cycle.
  always @(negedge clk) begin
    logic [14:0] act_s;
    exp_t e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act_s = {RA_OUT, RA_LOAD, OUT_LOAD, ALU_SUB, ALU_OUT, B_LOAD, A_OUT, A_LOAD,
               IR_OUT, IR_LOAD, ~ROM_LOW_OE, MAR_LOAD, PC_LOAD, PC_INC, PC_OUT};
      if (!e.skip) begin
        compared++;
        if (t_state !== e.t || HALTED !== e.h || act_s !== e.s ||
            {ir_opcode, ir_operand} !== e.ir) begin
          mismatched++;
          $display("FAIL %s (cycle %0d): got t=%0d halted=%0b strobes=%h ir=%h, want t=%0d halted=%0b strobes=%h ir=%h",
                   e.name, cyc, t_state, HALTED, act_s, {ir_opcode, ir_operand},
                   e.t, e.h, e.s, e.ir);
        end
      end
    end
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    cyc        = 0;
    rst        = 1'b1;
    run        = 1'b1;
    bus_in     = 8'h00;
    @(posedge clk);

    // Walk into T3 of an "out" instruction, then reset for two cycles.
    step("pre_t1",      0, 1, 8'h00, 3'd0, 0, FETCH1, 8'h00);
    step("pre_t2",      0, 1, 8'h8F, 3'd1, 0, FETCH2, 8'h00);
    step("rst_c1",      1, 1, 8'h00, 3'd2, 0, NONE,   8'h8F);
    step("rst_c2",      1, 1, 8'h00, 3'd0, 0, NONE,   8'h00);
    step("post_rst_t1", 0, 1, 8'h00, 3'd0, 0, FETCH1, 8'h00);

    // lda 8
    step("lda_t2", 0, 1, 8'h08, 3'd1, 0, FETCH2,           8'h00);
    step("lda_t3", 0, 1, 8'h00, 3'd2, 0, S_IR_OUT | S_MAR,  8'h08);
    step("lda_t4", 0, 1, 8'h00, 3'd3, 0, S_ROM | S_A_LOAD,  8'h08);

    // add 9
    step("add_t1", 0, 1, 8'h00, 3'd0, 0, FETCH1,                8'h08);
    step("add_t2", 0, 1, 8'h19, 3'd1, 0, FETCH2,                8'h08);
    step("add_t3", 0, 1, 8'h00, 3'd2, 0, S_IR_OUT | S_MAR,      8'h19);
    step("add_t4", 0, 1, 8'h00, 3'd3, 0, S_ROM | S_B_LOAD,      8'h19);
    step("add_t5", 0, 1, 8'h00, 3'd4, 0, S_ALU_OUT | S_A_LOAD,  8'h19);

    // sub A
    step("sub_t1", 0, 1, 8'h00, 3'd0, 0, FETCH1,                           8'h19);
    step("sub_t2", 0, 1, 8'h2A, 3'd1, 0, FETCH2,                           8'h19);
    step("sub_t3", 0, 1, 8'h00, 3'd2, 0, S_IR_OUT | S_MAR,                 8'h2A);
    step("sub_t4", 0, 1, 8'h00, 3'd3, 0, S_ROM | S_B_LOAD,                 8'h2A);
    step("sub_t5", 0, 1, 8'h00, 3'd4, 0, S_ALU_OUT | S_A_LOAD | S_ALU_SUB, 8'h2A);

    // call C
    step("call_t1", 0, 1, 8'h00, 3'd0, 0, FETCH1,                8'h2A);
    step("call_t2", 0, 1, 8'h6C, 3'd1, 0, FETCH2,                8'h2A);
    step("call_t3", 0, 1, 8'h00, 3'd2, 0, S_PC_OUT | S_RA_LOAD,  8'h6C);
    step("call_t4", 0, 1, 8'h00, 3'd3, 0, S_IR_OUT | S_PC_LOAD,  8'h6C);

    // ret
    step("ret_t1", 0, 1, 8'h00, 3'd0, 0, FETCH1,               8'h6C);
    step("ret_t2", 0, 1, 8'h70, 3'd1, 0, FETCH2,               8'h6C);
    step("ret_t3", 0, 1, 8'h00, 3'd2, 0, S_RA_OUT | S_PC_LOAD, 8'h70);

    // out 5
    step("out_t1", 0, 1, 8'h00, 3'd0, 0, FETCH1,                8'h70);
    step("out_t2", 0, 1, 8'h85, 3'd1, 0, FETCH2,                8'h70);
    step("out_t3", 0, 1, 8'h00, 3'd2, 0, S_A_OUT | S_OUT_LOAD,  8'h85);

    // bun 3
    step("bun_t1", 0, 1, 8'h00, 3'd0, 0, FETCH1,               8'h85);
    step("bun_t2", 0, 1, 8'h53, 3'd1, 0, FETCH2,               8'h85);
    step("bun_t3", 0, 1, 8'h00, 3'd2, 0, S_IR_OUT | S_PC_LOAD, 8'h53);

    // add 7 with a 3-cycle stall in T4
    step("stall_t1",  0, 1, 8'h00, 3'd0, 0, FETCH1,               8'h53);
    step("stall_t2",  0, 1, 8'h17, 3'd1, 0, FETCH2,               8'h53);
    step("stall_t3",  0, 1, 8'h00, 3'd2, 0, S_IR_OUT | S_MAR,     8'h17);
    step("stall_h1",  0, 0, 8'h00, 3'd3, 0, NONE,                 8'h17);
    step("stall_h2",  0, 0, 8'h00, 3'd3, 0, NONE,                 8'h17);
    step("stall_h3",  0, 0, 8'h00, 3'd3, 0, NONE,                 8'h17);
    step("stall_t4",  0, 1, 8'h00, 3'd3, 0, S_ROM | S_B_LOAD,     8'h17);
    step("stall_t5",  0, 1, 8'h00, 3'd4, 0, S_ALU_OUT | S_A_LOAD, 8'h17);

    // nop 35, with a stalled T2 that must not capture the bus
    step("nop_t1",     0, 1, 8'h00, 3'd0, 0, FETCH1, 8'h17);
    step("nop_t2hold", 0, 0, 8'hFF, 3'd1, 0, NONE,   8'h17);
    step("nop_t2",     0, 1, 8'h35, 3'd1, 0, FETCH2, 8'h17);
    step("nop_t3",     0, 1, 8'h00, 3'd2, 0, NONE,   8'h35);

    // hlt
    step("hlt_t1", 0, 1, 8'h00, 3'd0, 0, FETCH1, 8'h35);
    step("hlt_t2", 0, 1, 8'hFF, 3'd1, 0, FETCH2, 8'h35);
    step("hlt_t3", 0, 1, 8'h00, 3'd2, 0, NONE,   8'hFF);
    for (int i = 0; i < 10; i++)
      step("halted", 0, 1, 8'h00, 3'd7, 1, NONE, 8'hFF);
    step("halted_norun", 0, 0, 8'h00, 3'd7, 1, NONE, 8'hFF);

    // Reset out of HALT; the first rst cycle is still pre-edge HALT state.
    step("hrst_c1",  1, 1, 8'h00, 3'd7, 0, NONE,   8'hFF, 1'b1);
    step("hrst_c2",  1, 1, 8'h00, 3'd0, 0, NONE,   8'h00);
    step("hrst_t1",  0, 1, 8'h00, 3'd0, 0, FETCH1, 8'h00);
    step("hrst_t2",  0, 1, 8'h00, 3'd1, 0, FETCH2, 8'h00);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      mismatched++;
      $display("FAIL drain: got %0d expectations left, want 0", exp_q.size());
    end
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
